mod_addsub_ctrl: RTL
====================

# mod_addsub_ctrl

Sequencer that computes modular addition or subtraction, (A ± B) mod M, on 1028-bit operands by driving the shared 1028-bit adder/subtractor through its start/done handshake. It issues one or two adder passes per operation: the raw sum or difference, then a conditional correction by M. It sits between the exponentiation/Montgomery control layer and the adder instance. It owns the adder's start, subtract, shift and operand inputs for the duration of an operation.

## Interface
- No parameters; operand width fixed at 1028 bits, adder result width 1029 bits.
- clk  in  1  single clock, rising edge
- resetn  in  1  synchronous, active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- subtract  in  1  0 = (A+B) mod M, 1 = (A−B) mod M; sampled with start
- in_a, in_b, in_m  in  1028 each  operands and modulus; sampled with start; caller guarantees A, B < M < 2^1027
- result  out  1028  modular result; valid from done, held until next accepted start
- done  out  1  one-cycle pulse when result is valid
- busy  out  1  high in every state except IDLE
- add_start  out  1  one-cycle pulse to adder
- add_subtract  out  1  adder mode for the current pass
- add_shift  out  1  tied 0
- add_in_a, add_in_b  out  1028 each  adder operands, registered, stable from ISSUE through WAIT
- add_result  in  1029  adder output; bit 1028 = carry (add) / borrow-sign (sub)
- add_done  in  1  adder result valid; may be constantly 1 or delayed

## Operation
- States: IDLE, ISSUE1, WAIT1, ISSUE2, WAIT2, DONE.
- IDLE: on start, latch A, B, M, op into registers → ISSUE1. start in any other state is ignored (no queueing).
- ISSUE1: add_start=1, add_in_a=A, add_in_b=B, add_subtract=op → WAIT1.
- WAIT1: hold operands; add_done sampled only here (never in ISSUE cycle). On add_done, capture S1=add_result.
  - op=add → ISSUE2 (always two passes).
  - op=sub, S1[1028]=0 → result=S1[1027:0], → DONE.
  - op=sub, S1[1028]=1 → ISSUE2.
- ISSUE2: add_start=1, add_in_a=S1[1027:0], add_in_b=M, add_subtract=~op → WAIT2.
- WAIT2: on add_done, S2=add_result.
  - op=add: S2[1028]=1 (S1<M) → result=S1[1027:0]; else result=S2[1027:0].
  - op=sub: result=S2[1027:0] (carry discarded).
  - → DONE.
- DONE: done=1 for one cycle → IDLE. start asserted in DONE is ignored; it is accepted only from IDLE.
- Width rules: A+B < 2^1028, so S1 never overflows 1028 bits; the comparison uses bit 1028 of the subtract pass only.
- Reset (any state, including mid-pass): next state IDLE; result=0, done=0, busy=0, add_start=0, add_subtract=0, add_in_a=add_in_b=0. An in-flight adder result is discarded.

## Timing
- All outputs registered; reset values as above.
- start sampled at cycle T. With add_done≡1:
  - add: add_start high at T+1 and T+3; done at T+5.
  - sub, no correction: done at T+3.
  - sub, corrected: done at T+5.
- Each cycle of add_done low in WAIT1/WAIT2 adds one cycle of latency.
- busy rises at T+1 and falls the cycle after done.
- Earliest next accepted start is the first IDLE cycle (T+6 for add).

## Test plan
- M=13, A=7, B=9, add; adder done≡1 → add_start pulses at T+1 and T+3; done at T+5; result=3.
- M=13, A=3, B=5, add → two passes still issued; result=8 at T+5. Repeat with A=6, B=7 → result=0 (equality boundary).
- M=13, A=9, B=4, sub → single pass; done at T+3; result=5; add_start pulses exactly once. A=3, B=5 sub → done at T+5; result=11.
- Adder model with add_done low for 3 cycles after each add_start; A=7, B=9, M=13 add → result=3 at T+11. No capture of stale add_result occurs during the low cycles.
- resetn low for one cycle while in WAIT2 → next cycle in IDLE; busy=0, done=0, result=0. A following start completes normally.
- start held high across an entire add operation → exactly one done per IDLE acceptance. Operand changes while busy do not affect result; sub with A=0, B=12, M=13 → result=1.

Source files
------------

// File: rtl/mod_addsub_ctrl_if.sv
// mod_addsub_ctrl_if: request/result bus plus the shared 1028-bit adder handshake.
interface mod_addsub_ctrl_if;
  logic          start;
  logic          subtract;
  logic [1027:0] in_a;
  logic [1027:0] in_b;
  logic [1027:0] in_m;
  logic [1027:0] result;
  logic          done;
  logic          busy;
  logic          add_start;
  logic          add_subtract;
  logic          add_shift;
  logic [1027:0] add_in_a;
  logic [1027:0] add_in_b;
  logic [1028:0] add_result;
  logic          add_done;
  modport master (
    output start, subtract, in_a, in_b, in_m, add_result, add_done,
    input  result, done, busy, add_start, add_subtract, add_shift, add_in_a, add_in_b
  );
  modport slave (
    input  start, subtract, in_a, in_b, in_m, add_result, add_done,
    output result, done, busy, add_start, add_subtract, add_shift, add_in_a, add_in_b
  );
endinterface

// File: rtl/mod_addsub_ctrl.sv
// mod_addsub_ctrl: (A +/- B) mod M via one or two passes through the shared adder.
module mod_addsub_ctrl (
  input logic             clk,
  input logic             resetn,
  mod_addsub_ctrl_if.slave bus
);
  typedef enum logic [2:0] {IDLE, ISSUE1, WAIT1, ISSUE2, WAIT2, DONE} state_t;
  state_t        r_state;
  logic          r_sub;
  logic          r_done;
  logic          r_busy;
  logic          r_add_start;
  logic          r_add_sub;
  logic [1027:0] r_m;
  logic [1027:0] r_result;
  logic [1027:0] r_add_a;
  logic [1027:0] r_add_b;
  assign bus.result       = r_result;
  assign bus.done         = r_done;
  assign bus.busy         = r_busy;
  assign bus.add_start    = r_add_start;
  assign bus.add_subtract = r_add_sub;
  assign bus.add_shift    = 1'b0;
  assign bus.add_in_a     = r_add_a;
  assign bus.add_in_b     = r_add_b;
  // During WAIT2 r_add_a still holds S1, so it doubles as the uncorrected result
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state     <= IDLE;
      r_done      <= 1'b0;
      r_busy      <= 1'b0;
      r_add_start <= 1'b0;
      r_add_sub   <= 1'b0;
      r_result    <= '0;
      r_add_a     <= '0;
      r_add_b     <= '0;
    end else begin
      r_add_start <= 1'b0;
      r_done      <= 1'b0;
      case (r_state)
        IDLE: if (bus.start) begin
          r_state     <= ISSUE1;
          r_busy      <= 1'b1;
          r_add_start <= 1'b1;
          r_add_a     <= bus.in_a;
          r_add_b     <= bus.in_b;
          r_add_sub   <= bus.subtract;
          r_sub       <= bus.subtract;
          r_m         <= bus.in_m;
        end
        ISSUE1: r_state <= WAIT1;
        WAIT1: if (bus.add_done) begin
          if (r_sub && !bus.add_result[1028]) begin
            r_result <= bus.add_result[1027:0];
            r_done   <= 1'b1;
            r_state  <= DONE;
          end else begin
            r_state     <= ISSUE2;
            r_add_start <= 1'b1;
            r_add_a     <= bus.add_result[1027:0];
            r_add_b     <= r_m;
            r_add_sub   <= ~r_sub;
          end
        end
        ISSUE2: r_state <= WAIT2;
        WAIT2: if (bus.add_done) begin
          r_result <= (!r_sub && bus.add_result[1028]) ? r_add_a : bus.add_result[1027:0];
          r_done   <= 1'b1;
          r_state  <= DONE;
        end
        DONE: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
